shadow_bank_spill_ctrl: RTL and testbench

Multi-bank shadow register controller, the successor to the single-save shadow unit. It manages `NR_BANKS` hardware register banks as a circular window over a nested-trap stack. Trap entry and return switch banks in zero stall cycles while a bank is free or resident. When the window overflows, the oldest bank is spilled to a dedicated shadow-stack memory region; when the window underflows, that bank is filled back. It sits between the issue stage (save/restore triggers), the banked register file, and the data-cache request port.

---
 rtl/shadow_bank_spill_ctrl_pkg.sv | 35 +++
 rtl/shru_mem_port.sv | 109 ++++++++++
 rtl/shadow_bank_spill_ctrl.sv | 155 +++++++++++++++
 tb/tb_shadow_bank_spill_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_bank_spill_ctrl_pkg.sv
// Shared types for the multi-bank shadow register controller: sequencer states
// and the frame geometry derived from the block parameters.
package shadow_bank_spill_ctrl_pkg;

   typedef enum logic [1:0] {
      SHRU_IDLE,
      SHRU_SPILL_REQ,
      SHRU_FILL_REQ,
      SHRU_FILL_RESP
   } shru_state_e;

   typedef struct packed {
      int bytes;
      int frame_bytes;
      int bank_w;
      int word_w;
      int level_w;
      int res_w;
   } shru_frame_cfg_t;

   function automatic shru_frame_cfg_t shru_frame_cfg(input int data_width,
                                                      input int nr_banks,
                                                      input int nr_saved_regs,
                                                      input int max_nest);
      shru_frame_cfg_t cfg;
      cfg.bytes       = data_width / 8;
      cfg.frame_bytes = nr_saved_regs * (data_width / 8);
      cfg.bank_w      = $clog2(nr_banks);
      cfg.word_w      = $clog2(nr_saved_regs);
      cfg.level_w     = $clog2(max_nest + 1);
      cfg.res_w       = $clog2(nr_banks + 1);
      return cfg;
   endfunction

endpackage

// File: rtl/shru_mem_port.sv
// Request/grant/response sequencer and word counter shared by frame spill
// (stores, one per grant) and frame fill (one outstanding load at a time).
module shru_mem_port
   import shadow_bank_spill_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int NR_SAVED_REGS = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             spill_start_i,
   input  logic                             fill_start_i,
   input  logic [DATA_WIDTH-1:0]            sp_i,
   input  logic                             mem_gnt_i,
   input  logic                             mem_rvalid_i,
   output logic                             busy_o,
   output logic                             spill_done_o,
   output logic                             fill_done_o,
   output logic                             word_we_o,
   output logic [$clog2(NR_SAVED_REGS)-1:0] word_o,
   output logic                             mem_req_o,
   output logic                             mem_we_o,
   output logic [DATA_WIDTH-1:0]            mem_addr_o
);

   localparam shru_frame_cfg_t CFG = shru_frame_cfg(DATA_WIDTH, 2, NR_SAVED_REGS, 2);
   localparam int WORD_W = CFG.word_w;
   localparam logic [DATA_WIDTH-1:0] FRAME_BYTES = DATA_WIDTH'(CFG.frame_bytes);
   localparam logic [DATA_WIDTH-1:0] WORD_BYTES  = DATA_WIDTH'(CFG.bytes);
   localparam logic [WORD_W-1:0]     LAST_WORD   = WORD_W'(NR_SAVED_REGS - 1);

   shru_state_e           state_q, state_d;
   logic [WORD_W-1:0]     word_q, word_d;
   logic                  last_word;
   logic [DATA_WIDTH-1:0] word_off;

   assign last_word = (word_q == LAST_WORD);
   assign word_off  = DATA_WIDTH'(word_q) * WORD_BYTES;
   assign busy_o    = (state_q != SHRU_IDLE);
   assign word_o    = word_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SHRU_IDLE;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      word_we_o    = 1'b0;
      spill_done_o = 1'b0;
      fill_done_o  = 1'b0;
      unique case (state_q)
         SHRU_IDLE: begin
            word_d = '0;
            if (spill_start_i) begin
               state_d = SHRU_SPILL_REQ;
            end else if (fill_start_i) begin
               state_d = SHRU_FILL_REQ;
            end
         end
         SHRU_SPILL_REQ: begin
            // The frame sits just below the current stack pointer.
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = sp_i - FRAME_BYTES + word_off;
            if (mem_gnt_i) begin
               if (last_word) begin
                  spill_done_o = 1'b1;
                  word_d       = '0;
                  state_d      = SHRU_IDLE;
               end else begin
                  word_d = word_q + 1'b1;
               end
            end
         end
         SHRU_FILL_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = sp_i + word_off;
            if (mem_gnt_i) begin
               state_d = SHRU_FILL_RESP;
            end
         end
         SHRU_FILL_RESP: begin
            if (mem_rvalid_i) begin
               word_we_o = 1'b1;
               if (last_word) begin
                  fill_done_o = 1'b1;
                  word_d      = '0;
                  state_d     = SHRU_IDLE;
               end else begin
                  word_d  = word_q + 1'b1;
                  state_d = SHRU_FILL_REQ;
               end
            end
         end
         default: state_d = SHRU_IDLE;
      endcase
   end

endmodule

// File: rtl/shadow_bank_spill_ctrl.sv
// Multi-bank shadow register controller: a circular window of register banks
// over a nested trap stack, spilling/filling the oldest frame to memory.
module shadow_bank_spill_ctrl
   import shadow_bank_spill_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int NR_BANKS      = 4,
   parameter int NR_SAVED_REGS = 16,
   parameter int MAX_NEST      = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             save_i,
   input  logic                             restore_i,
   output logic                             ready_o,
   output logic                             error_o,
   output logic [$clog2(NR_BANKS)-1:0]      active_bank_o,
   output logic [$clog2(MAX_NEST+1)-1:0]    level_o,
   input  logic [DATA_WIDTH-1:0]            spill_base_i,
   output logic [$clog2(NR_BANKS)-1:0]      bank_rd_bank_o,
   output logic [$clog2(NR_SAVED_REGS)-1:0] bank_rd_addr_o,
   input  logic [DATA_WIDTH-1:0]            bank_rdata_i,
   output logic                             bank_we_o,
   output logic [$clog2(NR_BANKS)-1:0]      bank_wr_bank_o,
   output logic [$clog2(NR_SAVED_REGS)-1:0] bank_wr_addr_o,
   output logic [DATA_WIDTH-1:0]            bank_wdata_o,
   output logic                             mem_req_o,
   output logic                             mem_we_o,
   output logic [DATA_WIDTH-1:0]            mem_addr_o,
   output logic [DATA_WIDTH-1:0]            mem_wdata_o,
   input  logic                             mem_gnt_i,
   input  logic                             mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

   localparam shru_frame_cfg_t CFG =
      shru_frame_cfg(DATA_WIDTH, NR_BANKS, NR_SAVED_REGS, MAX_NEST);
   localparam int BANK_W  = CFG.bank_w;
   localparam int LEVEL_W = CFG.level_w;
   localparam int RES_W   = CFG.res_w;
   localparam int WORD_W  = CFG.word_w;
   localparam logic [DATA_WIDTH-1:0] FRAME_BYTES = DATA_WIDTH'(CFG.frame_bytes);

   logic [BANK_W-1:0]     oldest_q, oldest_d;
   logic [RES_W-1:0]      resident_q, resident_d;
   logic [LEVEL_W-1:0]    level_q, level_d;
   logic [DATA_WIDTH-1:0] spill_sp_q, spill_sp_d;
   logic                  error_q, error_d;
   logic                  busy, spill_start, fill_start, spill_done, fill_done, word_we;
   logic [WORD_W-1:0]     word;
   logic [BANK_W-1:0]     fill_bank;

   shru_mem_port #(
      .DATA_WIDTH   (DATA_WIDTH),
      .NR_SAVED_REGS(NR_SAVED_REGS)
   ) u_mem_port (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .spill_start_i(spill_start),
      .fill_start_i (fill_start),
      .sp_i         (spill_sp_q),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .busy_o       (busy),
      .spill_done_o (spill_done),
      .fill_done_o  (fill_done),
      .word_we_o    (word_we),
      .word_o       (word),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o)
   );

   // A refilled frame lands in the bank just below the oldest resident one.
   assign fill_bank     = oldest_q - BANK_W'(1);
   assign ready_o       = !busy;
   assign error_o       = error_q;
   assign level_o       = level_q;
   assign active_bank_o = (resident_q == '0) ? oldest_q
                                             : oldest_q + BANK_W'(resident_q - RES_W'(1));

   assign bank_rd_bank_o = oldest_q;
   assign bank_rd_addr_o = word;
   assign bank_we_o      = word_we;
   assign bank_wr_bank_o = word_we ? fill_bank : '0;
   assign bank_wr_addr_o = word_we ? word : '0;
   assign bank_wdata_o   = word_we ? mem_rdata_i : '0;
   assign mem_wdata_o    = mem_we_o ? bank_rdata_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         oldest_q   <= '0;
         resident_q <= '0;
         level_q    <= '0;
         spill_sp_q <= '0;
         error_q    <= 1'b0;
      end else begin
         oldest_q   <= oldest_d;
         resident_q <= resident_d;
         level_q    <= level_d;
         spill_sp_q <= spill_sp_d;
         error_q    <= error_d;
      end
   end

   always_comb begin
      oldest_d    = oldest_q;
      resident_d  = resident_q;
      level_d     = level_q;
      spill_sp_d  = spill_sp_q;
      error_d     = 1'b0;
      spill_start = 1'b0;
      fill_start  = 1'b0;

      if (!busy && (level_q == '0)) begin
         spill_sp_d = spill_base_i;
      end

      if (!busy && (save_i || restore_i)) begin
         if (save_i && restore_i) begin
            error_d = 1'b1;
         end else if (save_i) begin
            if (level_q == LEVEL_W'(MAX_NEST)) begin
               error_d = 1'b1;
            end else if (resident_q < RES_W'(NR_BANKS)) begin
               resident_d = resident_q + 1'b1;
               level_d    = level_q + 1'b1;
            end else begin
               spill_start = 1'b1;
            end
         end else begin
            if (level_q == '0) begin
               error_d = 1'b1;
            end else begin
               level_d    = level_q - 1'b1;
               resident_d = resident_q - 1'b1;
               fill_start = (resident_q == RES_W'(1)) && (level_q > LEVEL_W'(1));
            end
         end
      end

      // Spill frees the oldest bank and hands it straight to the new frame.
      if (spill_done) begin
         spill_sp_d = spill_sp_q - FRAME_BYTES;
         oldest_d   = oldest_q + 1'b1;
         level_d    = level_q + 1'b1;
      end
      if (fill_done) begin
         spill_sp_d = spill_sp_q + FRAME_BYTES;
         oldest_d   = fill_bank;
         resident_d = RES_W'(1);
      end
   end

endmodule

// File: tb/tb_shadow_bank_spill_ctrl.sv
// Randomized bench for shadow_bank_spill_ctrl: models the trap stack as frames
// in a window plus frames in memory, and checks register contents on return.
module tb_shadow_bank_spill_ctrl;
   localparam int DW = 64, NB = 2, NR = 4, MN = 16;
   localparam int FRAME = NR * (DW / 8);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           save = 1'b0, restore = 1'b0;
   logic           ready, error;
   logic [0:0]     active_bank, rd_bank, wr_bank;
   logic [4:0]     level;
   logic [1:0]     rd_addr, wr_addr;
   logic [DW-1:0]  spill_base, rdata, wdata;
   logic           bwe, mem_req, mem_we, gnt, rvalid;
   logic [DW-1:0]  mem_addr, mem_wdata, mem_rdata;

   shadow_bank_spill_ctrl #(
      .DATA_WIDTH(DW), .NR_BANKS(NB), .NR_SAVED_REGS(NR), .MAX_NEST(MN)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .save_i(save), .restore_i(restore),
      .ready_o(ready), .error_o(error), .active_bank_o(active_bank), .level_o(level),
      .spill_base_i(spill_base), .bank_rd_bank_o(rd_bank), .bank_rd_addr_o(rd_addr),
      .bank_rdata_i(rdata), .bank_we_o(bwe), .bank_wr_bank_o(wr_bank),
      .bank_wr_addr_o(wr_addr), .bank_wdata_o(wdata), .mem_req_o(mem_req),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(mem_rdata)
   );

   // Register file owned by the bench: fill writes from the DUT, frame writes from the core.
   logic [DW-1:0] rf [NB][NR];
   logic          core_we = 1'b0;
   logic [0:0]    core_bank = '0;
   logic [1:0]    core_word = '0;
   logic [DW-1:0] core_data = '0;
   assign rdata = rf[rd_bank][rd_addr];
   always @(posedge clk) begin
      if (bwe) rf[wr_bank][wr_addr] <= wdata;
      if (core_we) rf[core_bank][core_word] <= core_data;
   end

   typedef struct { logic we; logic [DW-1:0] addr; logic [DW-1:0] data; } exp_t;
   exp_t          exp_q[$];
   int            gnt_plan[$];
   int            rv_fixed = -1;
   int            n_grants = 0;
   logic [DW-1:0] mem [logic [DW-1:0]];

   int n_checks = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Memory: grants after a planned or random delay, load data 1..3 cycles later.
   initial begin : responder
      int gnt_cnt, resp_cnt;
      bit resp_pend;
      logic [DW-1:0] resp_addr;
      exp_t e;
      gnt_cnt = -1; resp_cnt = 0; resp_pend = 1'b0; resp_addr = '0;
      gnt = 1'b0; rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         gnt = 1'b0; rvalid = 1'b0; mem_rdata = '0;
         if (!rst_n) begin
            gnt_cnt = -1; resp_pend = 1'b0;
         end else if (resp_pend) begin
            if (resp_cnt == 0) begin
               rvalid = 1'b1;
               mem_rdata = mem.exists(resp_addr) ? mem[resp_addr] : '0;
               resp_pend = 1'b0;
            end else resp_cnt--;
         end else if (mem_req) begin
            if (gnt_cnt < 0)
               gnt_cnt = (gnt_plan.size() != 0) ? gnt_plan.pop_front() : int'($urandom_range(0, 2));
            if (gnt_cnt == 0) begin
               gnt = 1'b1; gnt_cnt = -1; n_grants++;
               if (exp_q.size() == 0) begin
                  chk("req_unexpected", 64'(mem_req), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("req_we", 64'(mem_we), 64'(e.we));
                  chk("req_addr", mem_addr, e.addr);
                  if (mem_we) begin
                     chk("store_data", mem_wdata, e.data);
                     mem[mem_addr] = mem_wdata;
                  end else begin
                     resp_pend = 1'b1;
                     resp_addr = mem_addr;
                     resp_cnt = ((rv_fixed > 0) ? rv_fixed : int'($urandom_range(1, 3))) - 1;
                  end
               end
            end else gnt_cnt--;
         end
      end
   end

   // Reference model: m_level frames on the stack, m_spilled of them in memory.
   int            m_level = 0, m_spilled = 0;
   logic [DW-1:0] m_base = '0;
   logic [DW-1:0] stack [MN+1][NR];
   bit            a0_mode = 1'b0;

   task automatic do_op(input int kind, output int lowc);
      bit s, r, err_exp, spill_exp, fill_exp;
      logic [DW-1:0] d;
      exp_t e;
      s = (kind != 1);
      r = (kind != 0);
      if (m_level == 0) m_base = spill_base;
      err_exp   = (s && r) || (s && m_level == MN) || (r && m_level == 0);
      spill_exp = !err_exp && s && (m_level - m_spilled == NB);
      fill_exp  = !err_exp && r && (m_level - 1 - m_spilled == 0) && (m_level - 1 > 0);
      if (spill_exp)
         for (int i = 0; i < NR; i++) begin
            e.we = 1'b1;
            e.addr = m_base - 64'(FRAME * (m_spilled + 1)) + 64'(i * 8);
            e.data = stack[m_spilled + 1][i];
            exp_q.push_back(e);
         end
      if (fill_exp)
         for (int i = 0; i < NR; i++) begin
            e.we = 1'b0;
            e.addr = m_base - 64'(FRAME * m_spilled) + 64'(i * 8);
            e.data = '0;
            exp_q.push_back(e);
         end
      @(negedge clk);
      save = s; restore = r;
      @(negedge clk);
      save = 1'b0; restore = 1'b0;
      chk("error", 64'(error), 64'(err_exp));
      chk("ready_after_accept", 64'(ready), 64'(!(spill_exp || fill_exp)));
      lowc = 0;
      while (!ready && lowc < 400) begin lowc++; @(negedge clk); end
      if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
      if (err_exp) begin
         @(negedge clk);
         chk("error_pulse_end", 64'(error), 64'd0);
      end else if (s) begin
         if (spill_exp) m_spilled++;
         m_level++;
      end else begin
         m_level--;
         if (fill_exp) m_spilled--;
      end
      chk("level", 64'(level), 64'(m_level));
      chk("exp_drained", 64'(exp_q.size()), 64'd0);
      if (!err_exp && s) begin
         for (int i = 0; i < NR; i++) begin
            d = (a0_mode && m_level == 1) ? 64'hA0 + 64'(i) : {$urandom, $urandom};
            stack[m_level][i] = d;
            core_we = 1'b1; core_bank = active_bank; core_word = 2'(i); core_data = d;
            @(negedge clk);
         end
         core_we = 1'b0;
      end
      if (!err_exp && r && m_level > 0)
         for (int i = 0; i < NR; i++)
            chk("frame_word", rf[active_bank][i], stack[m_level][i]);
      $display("op=%s level=%0d bank=%0d err=%0b busy_cycles=%0d spilled=%0d",
               (kind == 0) ? "save" : (kind == 1) ? "restore" : "both",
               level, active_bank, err_exp, lowc, m_spilled);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_bank_we", 64'(bwe), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_active", 64'(active_bank), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_rd_bank", 64'(rd_bank), 64'd0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin : main
      int lowc, g0, cnt;
      spill_base = 64'h8000_1000;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;
      a0_mode = 1'b1;

      do_op(0, lowc); chk("plan_active_1", 64'(active_bank), 64'd0);
      do_op(0, lowc); chk("plan_active_2", 64'(active_bank), 64'd1);
      gnt_plan = '{0, 2, 0, 1};
      do_op(0, lowc);
      chk("plan_spill_busy", 64'(lowc), 64'd7);
      chk("plan_active_3", 64'(active_bank), 64'd0);
      chk("plan_level_3", 64'(level), 64'd3);
      rv_fixed = 3;
      repeat (3) do_op(1, lowc);
      rv_fixed = -1;
      a0_mode = 1'b0;
      do_op(1, lowc);
      do_op(2, lowc);

      for (int i = 0; i < MN + 1; i++) do_op(0, lowc);
      chk("max_nest_level", 64'(level), 64'(MN));
      for (int i = 0; i < MN; i++) do_op(1, lowc);

      // Abort a spill after two grants.
      do_op(0, lowc); do_op(0, lowc);
      gnt_plan = '{0, 1, 1, 1};
      for (int i = 0; i < NR; i++) begin
         exp_t e;
         e.we = 1'b1; e.addr = m_base - 64'(FRAME) + 64'(i * 8); e.data = stack[1][i];
         exp_q.push_back(e);
      end
      g0 = n_grants;
      @(negedge clk); save = 1'b1;
      @(negedge clk); save = 1'b0;
      cnt = 0;
      while (n_grants < g0 + 2 && cnt < 100) begin @(negedge clk); cnt++; end
      chk("grants_before_reset", 64'(n_grants - g0), 64'd2);
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs();
      m_level = 0; m_spilled = 0; exp_q.delete(); gnt_plan.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      do_op(0, lowc);
      chk("post_reset_fast_path", 64'(lowc), 64'd0);

      for (int n = 0; n < 150; n++) begin
         int k;
         k = int'($urandom_range(0, 9));
         if (m_level == 0 && $urandom_range(0, 2) == 0)
            spill_base = {$urandom, $urandom} & ~64'h7;
         do_op((k < 5) ? 0 : (k < 9) ? 1 : 2, lowc);
      end
      while (m_level > 0) do_op(1, lowc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
